// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default
// vector layout and the special opcodes the fetch stage recognises.
package int_pkg;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_ISSUE   = 2'd1,
        IC_SERVICE = 2'd2
    } ic_state_t;

    localparam logic [9:0] DEF_VEC_BASE   = 10'd512;
    localparam logic [9:0] DEF_VEC_STRIDE = 10'd16;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_RETI = 8'hF0;
    localparam logic [7:0] OP_HALT = 8'hFF;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder: bit 0 has the highest priority.
module int_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [2:0]   idx
);

    always_comb begin
        valid = |req;
        idx   = 3'd0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Edge-latched, maskable interrupt controller feeding the fetch/decode stage;
// issues one interrupt at a time and waits for the CPU to return from service.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IC_IDLE    | no interrupt in flight; arbitrate eligible sources
//   IC_ISSUE   | one-cycle pulse on int_occured with vector on int_pc
//   IC_SERVICE | handler running; wait for available_for_int to return to 1
module int_ctrl
    import int_pkg::*;
#(
    parameter int              NUM_SRC    = 4,
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(DEF_VEC_BASE),
    parameter logic [PC_W-1:0] VEC_STRIDE = PC_W'(DEF_VEC_STRIDE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               available_for_int,
    output logic               int_occured,
    output logic [PC_W-1:0]    int_pc,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic               busy,
    output logic [2:0]         active_id
);

    ic_state_t          state, state_nxt;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] win_onehot;
    logic [NUM_SRC-1:0] win_clr;
    logic               win_valid;
    logic [2:0]         win_idx;
    logic [PC_W-1:0]    win_vec;
    logic               issue;

    assign rise       = irq & ~irq_q;
    assign eligible   = pending & ~mask;
    assign win_onehot = NUM_SRC'(1) << win_idx;
    assign win_clr    = issue ? win_onehot : '0;
    // Address arithmetic wraps at PC_W bits by construction.
    assign win_vec    = VEC_BASE + PC_W'(win_idx) * VEC_STRIDE;
    assign busy       = (state != IC_IDLE);

    int_prio_enc #(
        .N(NUM_SRC)
    ) u_prio_enc (
        .req  (eligible),
        .valid(win_valid),
        .idx  (win_idx)
    );

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IC_IDLE: begin
                if (win_valid && available_for_int) begin
                    state_nxt = IC_ISSUE;
                    issue     = 1'b1;
                end
            end
            // Fetch drops available_for_int combinationally here; ignore it.
            IC_ISSUE: state_nxt = IC_SERVICE;
            IC_SERVICE: begin
                if (available_for_int) state_nxt = IC_IDLE;
            end
            default: state_nxt = IC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IC_IDLE;
            irq_q       <= '0;
            pending     <= '0;
            mask        <= '0;
            int_occured <= 1'b0;
            int_pc      <= '0;
            active_id   <= 3'd0;
        end else begin
            state       <= state_nxt;
            irq_q       <= irq;
            // A new rise on the winner outranks its clear.
            pending     <= (pending & ~win_clr) | rise;
            int_occured <= issue;
            if (mask_we) mask <= mask_wdata;
            if (issue) begin
                int_pc    <= win_vec;
                active_id <= win_idx;
            end
        end
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller that sits directly upstream of the fetch/decode stage and drives its interrupt port (int_occured, int_pc, available_for_int). It latches rising edges on NUM_SRC request lines, applies a software mask, and picks the highest-priority pending source. It issues one interrupt at a time using the fetch stage's protocol: sample availability, present the vector, pulse int_occured for one cycle. It then holds off until the service routine's reti has returned the CPU to normal execution.

## Interface
- NUM_SRC, 4, number of interrupt request lines (1..8)
- PC_W, 10, width of instruction address / int_pc
- VEC_BASE, 10'd512, vector address of source 0
- VEC_STRIDE, 10'd16, address spacing between consecutive source vectors
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- irq  input  NUM_SRC  request lines, synchronous to clk; a 0->1 transition is one event
- mask_we  input  1  write strobe for the mask register
- mask_wdata  input  NUM_SRC  new mask value; bit=1 blocks issue of that source
- available_for_int  input  1  from fetch/decode; 1 = CPU in normal execution, interrupt will be accepted
- int_occured  output  1  registered one-cycle interrupt pulse to fetch/decode
- int_pc  output  PC_W  registered vector address; valid while int_occured=1
- pending  output  NUM_SRC  pending-event register
- mask  output  NUM_SRC  current mask register
- busy  output  1  1 in ISSUE or SERVICE
- active_id  output  3  index of the source being issued or serviced

## Operation
- Edge detect: irq_q <= irq each cycle. A rise is irq & ~irq_q. A rise sets pending[i] whether or not the source is masked.
- Eligible set = pending & ~mask. Winner = lowest set index (source 0 is highest priority).
- Vector = VEC_BASE + winner*VEC_STRIDE, computed modulo 2^PC_W (wrap, no saturation).
- The mask register loads mask_wdata on a mask_we cycle. The new mask affects eligibility from the next cycle.
- FSM states:
  - IDLE: go to ISSUE when eligible != 0 and available_for_int == 1.
  - ISSUE: lasts exactly 1 cycle, then always go to SERVICE.
  - SERVICE: go to IDLE when available_for_int == 1.
- Entering ISSUE:
  - int_occured <= 1, int_pc <= vector of winner, active_id <= winner.
  - pending[winner] is cleared.
- Simultaneous events:
  - If a new rise on the winner coincides with its clear, the set wins and pending stays 1.
  - Rises on other sources are captured as normal.
- No nesting: pending events accumulate during SERVICE and are arbitrated only after the return to IDLE.
- Halt: the halt state is terminal, so a halt in the ISSUE cycle leaves the FSM in SERVICE indefinitely. This is required behaviour and must not be treated as an error.
- Reset values: state=IDLE, irq_q=0, pending=0, mask=0 (all enabled), int_occured=0, int_pc=0, active_id=0, busy=0.
- Reset mid-operation: everything returns to reset values immediately and any in-flight pulse is dropped.

## Timing
- Latency:
  - irq rises before edge k; pending is set after edge k.
  - If available_for_int=1 in the following cycle, int_occured is high in the cycle after edge k+1.
  - Minimum latency is 2 cycles, rise to pulse.
- int_occured is never high for 2 consecutive cycles. It is driven only from a flop, which keeps the combinational path from int_occured back to available_for_int inside the fetch stage acyclic.
- int_pc changes only on entry to ISSUE and holds its value otherwise.
- Minimum spacing between two pulses: ISSUE, then at least one SERVICE cycle, then IDLE evaluation. That is 3 cycles.
- available_for_int is sampled only in IDLE and SERVICE. It is ignored in ISSUE, where the fetch stage lowers it combinationally.

## Structure
- Shared package int_pkg holds:
  - state encoding IC_IDLE=0, IC_ISSUE=1, IC_SERVICE=2;
  - the default VEC_BASE/VEC_STRIDE constants;
  - the special opcodes NOP/HALT/RETI.
- One sub-module, int_prio_enc: combinational lowest-index priority encoder giving a valid flag and a 3-bit index.

## Test plan
- Single source: mask=0, available=1, rise on irq[2] at cycle 5 -> int_occured=1 in cycle 7 only, int_pc=10'd544, pending[2] clears, busy=1 until available returns to 1.
- Priority: irq[3] and irq[1] rise in the same cycle -> first pulse has int_pc=528 and active_id=1. After available drops then returns to 1, the second pulse has int_pc=560.
- Masking: mask=4'b0001, irq[0] rises -> pending[0]=1 and no pulse. Writing mask=0 -> pulse with int_pc=512 two cycles later.
- Unavailable CPU: hold available=0 with irq[0] pending -> no pulse for 20 cycles. Raising available -> pulse on the next cycle.
- Set/clear collision and wrap: irq[1] rises again in the cycle its pending clears -> pending[1] stays 1. Check wrap with VEC_BASE=1016, VEC_STRIDE=16, source 1 -> int_pc=8.
- Reset during SERVICE: assert rst -> all outputs 0 asynchronously, pending=0. After deassertion, a fresh rise issues normally.
